uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
// - Parametrised UART transmitter with an internal write FIFO. Successor to the fixed 8-bit TX path.
// - Host pushes words via d_in/wr_en. Block serialises them onto tx as start/data/[parity]/stop frames.
// - Sits between the bus-side write driver and the serial pin. One clock domain.
// PARAMETERS
// - DATA_W        8   data bits per frame, legal 5..9
// - FIFO_DEPTH    16  FIFO entries, power of 2, >=2
// - CLKS_PER_BIT  16  clk cycles per serial bit, >=2
// - STOP_BITS     1   stop bits per frame, 1 or 2
// PORTS
// - clk         in   1                      system clock, rising edge
// - reset       in   1                      async, active-high; clears FIFO and FSM
// - d_in        in   DATA_W                 write data
// - wr_en       in   1                      write strobe; accepted when !tx_full
// - parity_odd  in   1                      1=odd, 0=even parity; sampled at pop
// - tx_full     out  1                      FIFO holds FIFO_DEPTH words
// - tx_empty    out  1                      FIFO holds 0 words
// - tx_busy     out  1                      FSM not IDLE (frame on line)
// - fifo_count  out  $clog2(FIFO_DEPTH)+1   words in FIFO
// - tx          out  1                      serial line, idle high, registered
// BEHAVIOUR
// - Clock/reset: single clock clk; reset is asynchronous, active-high.
// - Reset values: tx=1, tx_full=0, tx_empty=1, tx_busy=0, fifo_count=0, FSM=IDLE, baud counter=0.
// - Reset mid-frame: tx returns to 1 immediately (async). FIFO contents discarded. No partial frame resumes.
// - Write: wr_en && !tx_full pushes d_in.
//   - wr_en while tx_full: dropped, no state change. This applies even if a pop occurs in the same cycle.
// - Flags: tx_full/tx_empty decode the registered fifo_count.
//   - Simultaneous push+pop leaves count unchanged.
// - FSM states: IDLE, START, DATA, PARITY, STOP (enum).
//   - IDLE: if !tx_empty, pop, load shift reg, go to START. tx=0 from that edge.
//     Latency: tx falls on the first rising edge after the edge that wrote an empty FIFO.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//   - DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles. Bit index counter 0..DATA_W-1.
//   - PARITY: present only with the macro (see CONFIGURATION).
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the final cycle:
//     - if !tx_empty, pop and go directly to START (no idle gap);
//     - otherwise go to IDLE.
// - Baud counter: counts 0..CLKS_PER_BIT-1, cleared on every state entry.
//   - Wraps at CLKS_PER_BIT-1, which advances the bit or the state.
// - Frame length: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
// - tx_busy = (state != IDLE). tx is a registered output, glitch-free.
// - FIFO pointers: ($clog2(FIFO_DEPTH)) bits, natural wrap-around. Count is one bit wider.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - PARITY state follows DATA for CLKS_PER_BIT cycles.
//   - Bit = ^data (even) or ~^data (odd), per parity_odd latched at pop.
// - UART_TX_PARITY_EN undefined:
//   - DATA goes directly to STOP. parity_odd is ignored. The PARITY state is not synthesised.
// STRUCTURE
// - Package uart_tx_pkg: tx_state_e enum; IDLE_LEVEL=1'b1; START_LEVEL=1'b0.
// - Sub-module uart_tx_sync_fifo (DATA_W, FIFO_DEPTH):
//   - ports push/pop/din/dout/count/full/empty;
//   - dout valid in the same cycle as empty=0 (show-ahead).
// - Top: FSM, baud counter, bit counter, shift register, optional parity logic.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4, STOP_BITS=1)
// - Reset: assert reset mid-idle -> tx=1, tx_empty=1, tx_full=0, fifo_count=0, tx_busy=0.
// - Single write 0xA5 -> tx falls 1 edge later.
//   Line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. 40-cycle frame, tx_busy high throughout.
// - 6 back-to-back writes while idle (first popped next cycle) -> words 1-5 accepted, tx_full=1, word 6 dropped.
//   5 frames in 200 cycles with no idle cycle between stop and start.
// - Write when full with a simultaneous pop -> write rejected, fifo_count decrements by 1.
// - Reset asserted at cycle 10 of a frame with 2 words queued -> tx=1 same cycle, fifo_count=0.
//   After release, tx stays 1.
// - With UART_TX_PARITY_EN: 0x07, parity_odd=0 -> parity bit 1. parity_odd=1 -> parity bit 0. 44-cycle frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the parametrised UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Host-side bus of the UART transmitter: write port, parity select, status and serial line.
interface uart_tx_fifo_param_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    import uart_tx_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] d_in;
    logic              wr_en;
    logic              parity_odd;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_busy;
    logic [CW-1:0]     fifo_count;
    logic              tx;

    modport master (
        output d_in, wr_en, parity_odd,
        input  tx_full, tx_empty, tx_busy, fifo_count, tx
    );

    modport slave (
        input  d_in, wr_en, parity_odd,
        output tx_full, tx_empty, tx_busy, fifo_count, tx
    );

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head word whenever empty is low.
// Pushes into a full FIFO are ignored even if a pop happens in the same cycle.
module uart_tx_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; count moves only when exactly one of push/pop is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with internal write FIFO.
// Frames are start / DATA_W bits LSB first / optional parity / STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_fifo_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_fifo_param_if.slave  bus
);
    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(DATA_W);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    tx_state_e         state, state_n;
    logic [BW-1:0]     baud_cnt, baud_n;
    logic [BCW-1:0]    bit_cnt, bit_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic              tx_q, tx_n;
    logic              pop;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_n;
`else
    logic              unused_parity;
    assign unused_parity = bus.parity_odd;
`endif

    uart_tx_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.d_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.tx_full    = fifo_full;
    assign bus.tx_empty   = fifo_empty;
    assign bus.fifo_count = fifo_count;
    assign bus.tx_busy    = (state != IDLE);
    assign bus.tx         = tx_q;

    // Frame sequencer state, counters, shift register and the registered line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift_q  <= shift_n;
            tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

    // Next-state logic; the line level is derived from the next state so tx changes on the entry edge.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        pop     = 1'b0;
        tx_n    = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^fifo_dout) ^ bus.parity_odd;
`endif
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shift_n = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_n = fifo_dout;
                            state_n = START;
`ifdef UART_TX_PARITY_EN
                            par_n   = (^fifo_dout) ^ bus.parity_odd;
`endif
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   tx_n = START_LEVEL;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: a frame-level queue model checked every cycle,
// plus directed literal checks. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_fifo_param;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int CLKS_PER_BIT = 4;
    localparam int STOP_BITS    = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_BITS   = 1 + DATA_W + P + STOP_BITS;
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_tx_fifo_param_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_tx_fifo_param #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hand-derived line sequence for 0xA5 (even parity of 0xA5 is 0).
`ifdef UART_TX_PARITY_EN
    int a5_bits [FRAME_BITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    int a5_bits [FRAME_BITS] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic wr);
        @(negedge clk);
        bus.d_in  = data;
        bus.wr_en = wr;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitIdle(input int budget, input string name);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            @(negedge clk);
            if (!bus.tx_busy && bus.tx_empty) reached = 1'b1;
        end
        checkOutput(name, reached, 1);
    endtask

    // Line bit idx (0 = start) of a frame carrying word with the given parity mode.
    function automatic logic frame_bit(input int word, input bit podd, input int idx);
        logic [DATA_W-1:0] w;
        w = word[DATA_W-1:0];
        if (idx == 0) return 1'b0;
        if (idx <= DATA_W) return w[idx-1];
        if (P == 1 && idx == DATA_W + 1) return (^w) ^ podd;
        return 1'b1;
    endfunction

    // Reference model: a word queue plus the frame in flight and its cycle position.
    int model_q [$];
    bit m_busy = 1'b0;
    int m_pos  = 0;
    int m_word = 0;
    bit m_podd = 1'b0;
    int m_pre;
    bit m_push;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_q.delete();
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            m_pre  = model_q.size();
            m_push = bus.wr_en && (m_pre < FIFO_DEPTH);
            if (!m_busy || m_pos == FRAME_CYCLES - 1) begin
                if (m_pre > 0) begin
                    m_word = model_q.pop_front();
                    m_podd = bus.parity_odd;
                    m_busy = 1'b1;
                    m_pos  = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_pos++;
            end
            if (m_push) model_q.push_back(int'(bus.d_in));
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("cyc_tx", bus.tx,
                        m_busy ? frame_bit(m_word, m_podd, m_pos / CLKS_PER_BIT) : 1'b1);
            checkOutput("cyc_count", bus.fifo_count, model_q.size());
            checkOutput("cyc_full", bus.tx_full, model_q.size() == FIFO_DEPTH);
            checkOutput("cyc_empty", bus.tx_empty, model_q.size() == 0);
            checkOutput("cyc_busy", bus.tx_busy, m_busy);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        bus.d_in       = '0;
        bus.wr_en      = 1'b0;
        bus.parity_odd = 1'b0;

        // Power-on reset values
        waitCycles(3);
        checkOutput("rst_tx", bus.tx, 1);
        checkOutput("rst_empty", bus.tx_empty, 1);
        checkOutput("rst_full", bus.tx_full, 0);
        checkOutput("rst_count", bus.fifo_count, 0);
        checkOutput("rst_busy", bus.tx_busy, 0);
        @(negedge clk); #1 reset = 1'b0;
        waitCycles(3);

        // Reset asserted mid-idle
        #2 reset = 1'b1;
        #1;
        checkOutput("rst2_tx", bus.tx, 1);
        checkOutput("rst2_empty", bus.tx_empty, 1);
        checkOutput("rst2_full", bus.tx_full, 0);
        checkOutput("rst2_count", bus.fifo_count, 0);
        checkOutput("rst2_busy", bus.tx_busy, 0);
        @(negedge clk); #1 reset = 1'b0;
        waitCycles(2);

        // Single word 0xA5: tx falls one edge after the write edge
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("a5_pre_tx", bus.tx, 1);
        checkOutput("a5_pre_count", bus.fifo_count, 1);
        waitCycles(1);
        for (int j = 0; j < FRAME_BITS; j++) begin
            checkOutput("a5_bit", bus.tx, a5_bits[j]);
            checkOutput("a5_busy", bus.tx_busy, 1);
            waitCycles(CLKS_PER_BIT - 1);
            checkOutput("a5_bit_hold", bus.tx, a5_bits[j]);
            waitCycles(1);
        end
        checkOutput("a5_done_busy", bus.tx_busy, 0);
        checkOutput("a5_done_tx", bus.tx, 1);
        waitCycles(3);

        // Six back-to-back writes: five accepted, sixth dropped, frames seamless
        for (int k = 0; k < 6; k++) applyStimulus(8'h31 + 8'(k), 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("burst_full", bus.tx_full, 1);
        checkOutput("burst_count", bus.fifo_count, 4);
        waitCycles(FRAME_CYCLES - 5);
        checkOutput("burst_stop_tx", bus.tx, 1);
        waitCycles(1);
        checkOutput("burst_no_gap_tx", bus.tx, 0);
        checkOutput("burst_no_gap_busy", bus.tx_busy, 1);
        checkOutput("burst_no_gap_count", bus.fifo_count, 3);
        waitCycles(4 * FRAME_CYCLES - 1);
        checkOutput("burst_last_busy", bus.tx_busy, 1);
        waitCycles(1);
        checkOutput("burst_end_busy", bus.tx_busy, 0);
        checkOutput("burst_end_empty", bus.tx_empty, 1);
        waitCycles(3);

        // Write while full coinciding with a pop: write rejected, count drops by one
        for (int k = 0; k < 5; k++) applyStimulus(8'h41 + 8'(k), 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("fp_count_full", bus.fifo_count, 4);
        waitCycles(FRAME_CYCLES - 4);
        checkOutput("fp_before_full", bus.tx_full, 1);
        bus.d_in  = 8'hEE;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        checkOutput("fp_count_after", bus.fifo_count, 3);
        checkOutput("fp_full_after", bus.tx_full, 0);
        waitIdle(6 * FRAME_CYCLES, "fp_drain");
        waitCycles(2);

        // Reset at frame cycle 10 with two words queued
        for (int k = 0; k < 3; k++) applyStimulus(8'h51 + 8'(k), 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("mr_queued", bus.fifo_count, 2);
        waitCycles(9);
        checkOutput("mr_pre_tx", bus.tx, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("mr_tx", bus.tx, 1);
        checkOutput("mr_count", bus.fifo_count, 0);
        checkOutput("mr_busy", bus.tx_busy, 0);
        @(negedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("mr_after_tx", bus.tx, 1);
        end

`ifdef UART_TX_PARITY_EN
        // Parity of 0x07: even -> 1, odd -> 0; 44-cycle frame
        for (int m = 0; m < 2; m++) begin
            bus.parity_odd = m[0];
            applyStimulus(8'h07, 1'b1);
            applyStimulus(8'h00, 1'b0);
            waitCycles(1 + 9 * CLKS_PER_BIT);
            checkOutput("par_bit", bus.tx, (m == 0) ? 1 : 0);
            waitCycles(7);
            checkOutput("par_last_busy", bus.tx_busy, 1);
            waitCycles(1);
            checkOutput("par_end_busy", bus.tx_busy, 0);
            waitCycles(2);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
